// File: rtl/atmega_spi_s.sv
// atmega_spi_s: ATmega-compatible SPI slave on the 8-bit I/O register bus (SPCR/SPSR/SPDR).
// Optional build macro ATMEGA_SPI_S_OVR_EN: keep the unread byte and flag SPSR.OVR on overrun.
module atmega_spi_s #(
    parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 8'h20,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 8'h21,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 8'h22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
    input  logic                         wr_dat,
    input  logic                         rd_dat,
    input  logic [7:0]                   bus_dat_in,
    output logic [7:0]                   bus_dat_out,
    output logic                         int_out,
    input  logic                         int_rst,
    output logic                         io_connect,
    output logic                         io_conn_slave,
    input  logic                         sck,
    input  logic                         ss_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe
);

    logic [7:0] spcr_r;
    logic       spi2x_r;
    logic       spif_r;
    logic       wcol_r;
    logic       ovr_r;
    logic [7:0] rd_buf_r;
    logic [7:0] tx_buf_r;
    logic [7:0] tx_shift_r;
    logic [7:0] rx_shift_r;
    logic [2:0] bit_cnt_r;

    logic sck_s1_r, sck_s2_r, sck_s3_r;
    logic ss_n_s1_r, ss_n_s2_r, ss_n_s3_r;
    logic mosi_s1_r, mosi_s2_r;

    logic       spie_s, spe_s, dord_s, mstr_s, cpol_s, cpha_s;
    logic       active_s, sel_s, ss_fall_s;
    logic       sck_rise_s, sck_fall_s, lead_s, trail_s;
    logic       sample_s, shift_s, done_s;
    logic       spdr_wr_s, wr_ok_s, wr_acc_s, clear_s;
    logic [7:0] rx_next_s, tx_shifted_s;

    assign spie_s = spcr_r[7];
    assign spe_s  = spcr_r[6];
    assign dord_s = spcr_r[5];
    assign mstr_s = spcr_r[4];
    assign cpol_s = spcr_r[3];
    assign cpha_s = spcr_r[2];

    assign active_s      = spe_s & ~mstr_s;
    assign sel_s         = active_s & ~ss_n_s2_r;
    assign ss_fall_s     = sel_s & ss_n_s3_r;
    assign io_connect    = spe_s;
    assign io_conn_slave = ~mstr_s;
    assign int_out       = spif_r & spie_s;
    assign miso_oe       = sel_s;

    // Edge classification relative to the idle clock polarity and the capture phase
    always_comb begin
        sck_rise_s = sck_s2_r & ~sck_s3_r;
        sck_fall_s = ~sck_s2_r & sck_s3_r;
        lead_s     = cpol_s ? sck_fall_s : sck_rise_s;
        trail_s    = cpol_s ? sck_rise_s : sck_fall_s;
        sample_s   = sel_s & ~ss_fall_s & (cpha_s ? trail_s : lead_s);
        shift_s    = sel_s & ~ss_fall_s & (cpha_s ? lead_s : trail_s);
        done_s     = sample_s & (bit_cnt_r == 3'd7);
    end

    // Shift datapaths for both bit orders
    always_comb begin
        if (dord_s) begin
            rx_next_s    = {mosi_s2_r, rx_shift_r[7:1]};
            tx_shifted_s = {1'b0, tx_shift_r[7:1]};
            miso         = sel_s ? tx_shift_r[0] : 1'b1;
        end else begin
            rx_next_s    = {rx_shift_r[6:0], mosi_s2_r};
            tx_shifted_s = {tx_shift_r[6:0], 1'b0};
            miso         = sel_s ? tx_shift_r[7] : 1'b1;
        end
    end

    // An SPDR write is only safe between bytes, before the master starts clocking
    always_comb begin
        spdr_wr_s = wr_dat & (addr_dat == SPDR_ADDR);
        wr_ok_s   = ~sel_s | ss_fall_s | ((bit_cnt_r == 3'd0) & ~sample_s & ~shift_s);
        wr_acc_s  = spdr_wr_s & wr_ok_s;
        clear_s   = int_rst | (rd_dat & (addr_dat == SPSR_ADDR));
    end

    // Bus read mux
    always_comb begin
        bus_dat_out = 8'h00;
        if (rd_dat) begin
            case (addr_dat)
                SPCR_ADDR: bus_dat_out = spcr_r;
                SPSR_ADDR: bus_dat_out = {spif_r, wcol_r, 4'b0000, ovr_r, spi2x_r};
                SPDR_ADDR: bus_dat_out = rd_buf_r;
                default:   bus_dat_out = 8'h00;
            endcase
        end else begin
            bus_dat_out = 8'h00;
        end
    end

    // Pin synchronisers; ss_n idles high so a reset never looks like a select
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1_r  <= 1'b0;
            sck_s2_r  <= 1'b0;
            sck_s3_r  <= 1'b0;
            ss_n_s1_r <= 1'b1;
            ss_n_s2_r <= 1'b1;
            ss_n_s3_r <= 1'b1;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
        end else begin
            sck_s1_r  <= sck;
            sck_s2_r  <= sck_s1_r;
            sck_s3_r  <= sck_s2_r;
            ss_n_s1_r <= ss_n;
            ss_n_s2_r <= ss_n_s1_r;
            ss_n_s3_r <= ss_n_s2_r;
            mosi_s1_r <= mosi;
            mosi_s2_r <= mosi_s1_r;
        end
    end

    // Serial engine; the shift edge at bit_cnt 0 is the byte's first and never shifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift_r <= 8'h00;
            rx_shift_r <= 8'h00;
            bit_cnt_r  <= 3'd0;
        end else if (!sel_s) begin
            bit_cnt_r <= 3'd0;
            if (wr_acc_s) tx_shift_r <= bus_dat_in;
        end else if (ss_fall_s) begin
            bit_cnt_r  <= 3'd0;
            tx_shift_r <= wr_acc_s ? bus_dat_in : tx_buf_r;
        end else if (sample_s) begin
            rx_shift_r <= rx_next_s;
            if (bit_cnt_r == 3'd7) begin
                bit_cnt_r  <= 3'd0;
                tx_shift_r <= tx_buf_r;
            end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end else if (shift_s) begin
            if (bit_cnt_r != 3'd0) tx_shift_r <= tx_shifted_s;
        end else if (wr_acc_s) begin
            tx_shift_r <= bus_dat_in;
        end
    end

    // Register file and status flags; byte completion outranks clearing, clearing outranks writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spcr_r   <= 8'h00;
            spi2x_r  <= 1'b0;
            spif_r   <= 1'b0;
            wcol_r   <= 1'b0;
            ovr_r    <= 1'b0;
            rd_buf_r <= 8'h00;
            tx_buf_r <= 8'h00;
        end else begin
            if (wr_dat && (addr_dat == SPCR_ADDR)) spcr_r <= bus_dat_in;
            if (wr_dat && (addr_dat == SPSR_ADDR)) spi2x_r <= bus_dat_in[0];
            if (wr_acc_s) tx_buf_r <= bus_dat_in;

            if (done_s) spif_r <= 1'b1;
            else if (clear_s) spif_r <= 1'b0;

            if (clear_s) wcol_r <= 1'b0;
            else if (spdr_wr_s && !wr_ok_s) wcol_r <= 1'b1;
`ifdef ATMEGA_SPI_S_OVR_EN
            if (done_s && !spif_r) rd_buf_r <= rx_next_s;
            if (done_s && spif_r) ovr_r <= 1'b1;
            else if (clear_s) ovr_r <= 1'b0;
`else
            if (done_s) rd_buf_r <= rx_next_s;
            ovr_r <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_atmega_spi_s.sv
// Self-checking bench for atmega_spi_s: directed test-plan cases plus randomized transfers
// checked against a byte-level model of the register file.
module tb_atmega_spi_s;

    localparam logic [7:0] SPCR = 8'h20;
    localparam logic [7:0] SPSR = 8'h21;
    localparam logic [7:0] SPDR = 8'h22;
`ifdef ATMEGA_SPI_S_OVR_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] addr_dat = 8'h00, bus_dat_in = 8'h00, bus_dat_out;
    logic wr_dat = 1'b0, rd_dat = 1'b0, int_rst = 1'b0;
    logic int_out, io_connect, io_conn_slave, miso, miso_oe;
    logic sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;

    bit cpol, cpha, dord;
    logic [3:0] post_int;
    int n_tests = 0, n_fail = 0;

    // model state
    logic [7:0] m_spdr, m_txbuf;
    bit m_spif, m_wcol, m_ovr;

    atmega_spi_s dut (
        .clk(clk), .rst(rst), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
        .bus_dat_in(bus_dat_in), .bus_dat_out(bus_dat_out), .int_out(int_out),
        .int_rst(int_rst), .io_connect(io_connect), .io_conn_slave(io_conn_slave),
        .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_spsr();
        return {m_spif, m_wcol, 4'b0000, m_ovr, 1'b0};
    endfunction

    task automatic m_reset();
        m_spdr = 8'h00; m_txbuf = 8'h00; m_spif = 1'b0; m_wcol = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic m_complete(input logic [7:0] b);
        if (OVR_EN && m_spif) m_ovr = 1'b1;
        else m_spdr = b;
        m_spif = 1'b1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        addr_dat = a; bus_dat_in = d; wr_dat = 1'b1;
        @(negedge clk);
        wr_dat = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        addr_dat = a; rd_dat = 1'b1;
        #1 d = bus_dat_out;
        @(negedge clk);
        rd_dat = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a);
        logic [7:0] d;
        bus_rd(a, d);
        if (a == SPSR) begin
            check(tag, d, m_spsr());
            m_spif = 1'b0; m_wcol = 1'b0; m_ovr = 1'b0;
        end else begin
            check(tag, d, m_spdr);
        end
    endtask

    task automatic half_wait(input bit rec, input bit do_wr, input logic [7:0] wv);
        for (int k = 0; k < 4; k++) begin
            if (do_wr && k == 3) begin
                addr_dat = SPDR; bus_dat_in = wv; wr_dat = 1'b1;
            end
            @(negedge clk);
            if (rec) post_int[k] = int_out;
            wr_dat = 1'b0;
        end
    endtask

    // behavioural SPI master: nb bits of tx, optional SPDR write after sample edge wr_after
    task automatic xfer(input logic [7:0] tx, input int nb, input int wr_after,
                        input logic [7:0] wv, output logic [7:0] rx);
        int b;
        bit last, w;
        rx = 8'h00;
        if (ss_n) begin
            ss_n = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (!cpha) mosi = dord ? tx[0] : tx[7];
        for (int i = 0; i < nb; i++) begin
            b = dord ? i : 7 - i;
            last = (i == nb - 1);
            w = (i == wr_after - 1);
            if (!cpha) begin
                rx[b] = miso; sck = ~cpol;
                half_wait(last, w, wv);
                sck = cpol;
                if (i + 1 < nb) mosi = dord ? tx[i + 1] : tx[6 - i];
                half_wait(1'b0, 1'b0, wv);
            end else begin
                sck = ~cpol; mosi = tx[b];
                half_wait(1'b0, 1'b0, wv);
                rx[b] = miso; sck = cpol;
                half_wait(last, w, wv);
            end
        end
    endtask

    task automatic frame_end();
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic setup(input logic [7:0] spcr_v, input logic [7:0] tx);
        frame_end();
        cpol = spcr_v[3]; cpha = spcr_v[2]; dord = spcr_v[5];
        sck = cpol;
        bus_wr(SPCR, spcr_v);
        bus_wr(SPDR, tx);
        m_txbuf = tx;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] got, d, tx, rv, spcr_v;
        int nbytes, choice;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("rst_miso", {7'd0, miso}, 8'h01);
        check("rst_int", {7'd0, int_out}, 8'h00);
        check("rst_io_connect", {7'd0, io_connect}, 8'h00);
        check("rst_io_conn_slave", {7'd0, io_conn_slave}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        bus_rd(SPCR, d); check("rst_spcr", d, 8'h00);
        rd_check("rst_spsr", SPSR);
        rd_check("rst_spdr", SPDR);

        // mode 0, MSB first
        setup(8'h40, 8'hA5);
        check("m0_io_connect", {7'd0, io_connect}, 8'h01);
        xfer(8'h3C, 8, -1, 8'h00, got);
        m_complete(8'h3C);
        check("m0_miso", got, 8'hA5);
        check("m0_int", {7'd0, int_out}, 8'h00);
        rd_check("m0_spsr", SPSR);
        rd_check("m0_spdr", SPDR);

        // mode 3, LSB first, interrupt enabled
        setup(8'hED, 8'h81);
        xfer(8'h12, 8, -1, 8'h00, got);
        m_complete(8'h12);
        check("m3_miso", got, 8'h81);
        check("m3_spif_lat2", {7'd0, post_int[1]}, 8'h00);
        check("m3_spif_lat3", {7'd0, post_int[2]}, 8'h01);
        check("m3_int_hold", {7'd0, int_out}, 8'h01);
        rd_check("m3_spsr", SPSR);
        check("m3_int_clr", {7'd0, int_out}, 8'h00);
        rd_check("m3_spdr", SPDR);

        // write collision mid-byte
        setup(8'h40, 8'hAA);
        xfer(8'h5A, 8, 3, 8'h55, got);
        m_wcol = 1'b1;
        m_complete(8'h5A);
        check("wcol_miso", got, 8'hAA);
        rd_check("wcol_spsr", SPSR);
        xfer(8'h6B, 8, -1, 8'h00, got);
        m_complete(8'h6B);
        check("wcol_next_miso", got, 8'hAA);
        rd_check("wcol_next_spsr", SPSR);
        rd_check("wcol_spdr", SPDR);

        // abort after 5 bits, then a full byte
        setup(8'h40, 8'h3E);
        xfer(8'h77, 5, -1, 8'h00, got);
        frame_end();
        rd_check("abort_spsr", SPSR);
        xfer(8'h99, 8, -1, 8'h00, got);
        m_complete(8'h99);
        check("abort_miso", got, 8'h3E);
        frame_end();
        rd_check("abort_full_spsr", SPSR);
        rd_check("abort_once_spsr", SPSR);
        rd_check("abort_spdr", SPDR);

        // overrun: two bytes with no status read
        setup(8'h40, 8'h0F);
        xfer(8'h11, 8, -1, 8'h00, got); m_complete(8'h11);
        xfer(8'h22, 8, -1, 8'h00, got); m_complete(8'h22);
        frame_end();
        rd_check("ovr_spdr", SPDR);
        rd_check("ovr_spsr", SPSR);

        // asynchronous reset mid-byte
        setup(8'h40, 8'h5C);
        xfer(8'h33, 4, -1, 8'h00, got);
        rst = 1'b0;
        #1;
        m_reset();
        check("arst_miso_oe", {7'd0, miso_oe}, 8'h00);
        check("arst_int", {7'd0, int_out}, 8'h00);
        bus_rd(SPCR, d); check("arst_spcr", d, 8'h00);
        rd_check("arst_spsr", SPSR);
        rd_check("arst_spdr", SPDR);
        ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        setup(8'h40, 8'hC3);
        xfer(8'hE7, 8, -1, 8'h00, got);
        m_complete(8'hE7);
        check("arst_after_miso", got, 8'hC3);
        rd_check("arst_after_spsr", SPSR);
        rd_check("arst_after_spdr", SPDR);

        // randomized modes, data and flag handling
        for (int it = 0; it < 12; it++) begin
            spcr_v = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            tx = 8'($urandom_range(0, 255));
            setup(spcr_v, tx);
            nbytes = $urandom_range(1, 2);
            for (int j = 0; j < nbytes; j++) begin
                rv = 8'($urandom_range(0, 255));
                xfer(rv, 8, -1, 8'h00, got);
                m_complete(rv);
                check("rnd_miso", got, m_txbuf);
            end
            frame_end();
            check("rnd_int", {7'd0, int_out}, {7'd0, spcr_v[7] & m_spif});
            rd_check("rnd_spdr", SPDR);
            choice = $urandom_range(0, 2);
            if (choice == 0) begin
                rd_check("rnd_spsr", SPSR);
            end else if (choice == 1) begin
                int_rst = 1'b1;
                @(negedge clk);
                int_rst = 1'b0;
                m_spif = 1'b0; m_wcol = 1'b0; m_ovr = 1'b0;
            end
        end
        rd_check("final_spsr", SPSR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
